// File: rtl/multi_step_clk_pkg.sv
// Shared types and default sizes for the multi-step emulator clock generator.
//   mode_e  : step mode presented on mode_i and sampled on a go edge.
//   state_e : sequencing state of multi_step_clk.
package multi_step_clk_pkg;

  localparam int unsigned N_CH_DEF      = 1;
  localparam int unsigned CNT_WIDTH_DEF = 16;
  localparam int unsigned DT_WIDTH_DEF  = 25;
  localparam int unsigned MODE_WIDTH    = 2;

  typedef enum logic [MODE_WIDTH-1:0] {
    MODE_SINGLE = 2'd0,
    MODE_BURST  = 2'd1,
    MODE_FREE   = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FREE = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/multi_step_clk_rise_detect.sv
// Rising-edge detector for a level request.
//   __emu_clk   : clock
//   __emu_rst_n : synchronous active-low reset (clears the history bit)
//   sig         : level input
//   rise_c      : combinational pulse, high while sig is high and was low last cycle
module rise_detect (
  input  logic __emu_clk,
  input  logic __emu_rst_n,
  input  logic sig,
  output logic rise_c
);

  logic sig_prev;

  // History bit follows the input every cycle, regardless of what consumes the edge.
  always_ff @(posedge __emu_clk) begin
    if (!__emu_rst_n) begin
      sig_prev <= 1'b0;
    end else begin
      sig_prev <= sig;
    end
  end

  assign rise_c = sig & ~sig_prev;

endmodule

// File: rtl/multi_step_clk.sv
// Host-controlled stepping clock generator for the emulator.
// A rising edge on go_i in IDLE starts a single step, a fixed-length burst or
// a free run; stop_i ends a burst/free run early. Each step drives the latched
// channel mask on clk_val_o and the latched dt on dt_req_o for one cycle.
//   __emu_clk, __emu_rst_n : clock, synchronous active-low reset
//   go_i, stop_i           : start request (edge), abort (level)
//   mode_i, burst_len_i, ch_en_i, dt_step_i : run setup, sampled on go edge
//   clk_val_o, dt_req_o    : per-step clock enables and dt request
//   busy_o, done_o         : step-issued flag, end-of-run pulse
//   step_cnt_o             : wrapping count of steps issued since reset
module multi_step_clk
  import multi_step_clk_pkg::*;
#(
  parameter int unsigned N_CH      = N_CH_DEF,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int unsigned DT_WIDTH  = DT_WIDTH_DEF
) (
  input  logic                       __emu_clk,
  input  logic                       __emu_rst_n,
  input  logic                       go_i,
  input  logic                       stop_i,
  input  logic [MODE_WIDTH-1:0]      mode_i,
  input  logic [CNT_WIDTH-1:0]       burst_len_i,
  input  logic [N_CH-1:0]            ch_en_i,
  input  logic signed [DT_WIDTH-1:0] dt_step_i,
  output logic [N_CH-1:0]            clk_val_o,
  output logic signed [DT_WIDTH-1:0] dt_req_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [CNT_WIDTH-1:0]       step_cnt_o
);

  state_e                     state;
  logic [N_CH-1:0]            ch_en_q;
  logic signed [DT_WIDTH-1:0] dt_q;
  logic [CNT_WIDTH-1:0]       remaining;
  logic                       go_edge_c;
  mode_e                      mode_c;
  logic [N_CH-1:0]            step_ch_c;
  logic signed [DT_WIDTH-1:0] step_dt_c;

  rise_detect u_go_rise (
    .__emu_clk   (__emu_clk),
    .__emu_rst_n (__emu_rst_n),
    .sig         (go_i),
    .rise_c      (go_edge_c)
  );

  assign mode_c = mode_e'(mode_i);

  // The first step of a run is issued on the same edge that latches the setup,
  // so it has to take the live inputs; later steps use the latches.
  assign step_ch_c = (state == ST_IDLE) ? ch_en_i   : ch_en_q;
  assign step_dt_c = (state == ST_IDLE) ? dt_step_i : dt_q;

  // Sequencer with registered step/done outputs.
  // remaining counts the steps still owed including the one currently on the outputs.
  always_ff @(posedge __emu_clk) begin
    if (!__emu_rst_n) begin
      state      <= ST_IDLE;
      ch_en_q    <= '0;
      dt_q       <= '0;
      remaining  <= '0;
      clk_val_o  <= '0;
      dt_req_o   <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      step_cnt_o <= '0;
    end else begin
      clk_val_o <= '0;
      dt_req_o  <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;

      case (state)
        ST_IDLE: begin
          // stop_i in the go cycle suppresses the start entirely.
          if (go_edge_c && !stop_i) begin
            ch_en_q <= ch_en_i;
            dt_q    <= dt_step_i;
            case (mode_c)
              MODE_SINGLE: begin
                remaining  <= CNT_WIDTH'(1);
                state      <= ST_RUN;
                clk_val_o  <= step_ch_c;
                dt_req_o   <= step_dt_c;
                busy_o     <= 1'b1;
                step_cnt_o <= step_cnt_o + CNT_WIDTH'(1);
              end
              MODE_BURST: begin
                if (burst_len_i != '0) begin
                  remaining  <= burst_len_i;
                  state      <= ST_RUN;
                  clk_val_o  <= step_ch_c;
                  dt_req_o   <= step_dt_c;
                  busy_o     <= 1'b1;
                  step_cnt_o <= step_cnt_o + CNT_WIDTH'(1);
                end else begin
                  state  <= ST_DONE;
                  done_o <= 1'b1;
                end
              end
              MODE_FREE: begin
                state      <= ST_FREE;
                clk_val_o  <= step_ch_c;
                dt_req_o   <= step_dt_c;
                busy_o     <= 1'b1;
                step_cnt_o <= step_cnt_o + CNT_WIDTH'(1);
              end
              default: begin
                state <= ST_IDLE;
              end
            endcase
          end
        end

        ST_RUN: begin
          if (stop_i || (remaining == CNT_WIDTH'(1))) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end else begin
            remaining  <= remaining - CNT_WIDTH'(1);
            clk_val_o  <= step_ch_c;
            dt_req_o   <= step_dt_c;
            busy_o     <= 1'b1;
            step_cnt_o <= step_cnt_o + CNT_WIDTH'(1);
          end
        end

        ST_FREE: begin
          if (stop_i) begin
            state  <= ST_DONE;
            done_o <= 1'b1;
          end else begin
            clk_val_o  <= step_ch_c;
            dt_req_o   <= step_dt_c;
            busy_o     <= 1'b1;
            step_cnt_o <= step_cnt_o + CNT_WIDTH'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
